// File: rtl/autotune_pkg.sv
// Shared types and default sizing for the pitch-snap search path.
package autotune_pkg;

  localparam int DEF_WIDTH          = 12;
  localparam int DEF_HYST           = 4;
  localparam int DEF_TIMEOUT_CYCLES = 256;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    OUTPUT
  } req_state_t;

endpackage

// File: rtl/search_timer.sv
// Clearable up-counter that saturates at TIMEOUT_CYCLES-1 and flags it.
// Clear wins over enable; tc_out is decoded from the count register.
module search_timer #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic clk_in,
  input  logic rst_n_in,
  input  logic clr_in,
  input  logic en_in,
  output logic tc_out
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TC_VAL = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      cnt_q <= '0;
    end else if (clr_in) begin
      cnt_q <= '0;
    end else if (en_in && (cnt_q != TC_VAL)) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign tc_out = (cnt_q == TC_VAL);

endmodule

// File: rtl/search_requester.sv
// Issues one searcher request per new pitch, reuses the last target inside the
// hysteresis window, and falls back on timeout; target held until accepted.
module search_requester
  import autotune_pkg::*;
#(
  parameter int WIDTH          = DEF_WIDTH,
  parameter int HYST           = DEF_HYST,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             pitch_valid_in,
  input  logic [WIDTH-1:0] pitch_in,
  output logic             pitch_ready_out,
  output logic             search_start_out,
  output logic [WIDTH-1:0] search_val_out,
  input  logic [WIDTH-1:0] closest_value_in,
  input  logic             closest_found_in,
  output logic             target_valid_out,
  input  logic             target_ready_in,
  output logic [WIDTH-1:0] target_out,
  output logic             timeout_out,
  output logic [7:0]       timeout_count_out
);

  localparam logic [WIDTH-1:0] HYST_W = WIDTH'(HYST);

  function automatic logic [WIDTH-1:0] abs_diff(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  req_state_t       state_q;
  logic [WIDTH-1:0] pitch_q;
  logic [WIDTH-1:0] target_q;
  logic [WIDTH-1:0] last_pitch_q;
  logic [WIDTH-1:0] last_target_q;
  logic             have_target_q;
  logic             found_d_q;
  logic             timeout_q;
  logic [7:0]       tcnt_q;
  logic             timer_tc;
  logic             found_edge;

  search_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk_in  (clk_in),
    .rst_n_in(rst_n_in),
    .clr_in  (state_q == ISSUE),
    .en_in   (state_q == WAIT),
    .tc_out  (timer_tc)
  );

  assign found_edge = closest_found_in & ~found_d_q;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q       <= IDLE;
      pitch_q       <= '0;
      target_q      <= '0;
      last_pitch_q  <= '0;
      last_target_q <= '0;
      have_target_q <= 1'b0;
      found_d_q     <= 1'b0;
      timeout_q     <= 1'b0;
      tcnt_q        <= '0;
    end else begin
      timeout_q <= 1'b0;
      found_d_q <= closest_found_in;
      case (state_q)
        IDLE: begin
          if (pitch_valid_in) begin
            pitch_q <= pitch_in;
            if (pitch_in == '0) begin
              target_q      <= '0;
              have_target_q <= 1'b0;
              state_q       <= OUTPUT;
            end else if (have_target_q && (abs_diff(pitch_in, last_pitch_q) <= HYST_W)) begin
              target_q <= last_target_q;
              state_q  <= OUTPUT;
            end else begin
              state_q <= ISSUE;
            end
          end
        end
        ISSUE: begin
          // Preset so a found level left over from an earlier search is not an edge.
          found_d_q <= 1'b1;
          state_q   <= WAIT;
        end
        WAIT: begin
          if (found_edge) begin
            target_q      <= closest_value_in;
            last_pitch_q  <= pitch_q;
            last_target_q <= closest_value_in;
            have_target_q <= 1'b1;
            state_q       <= OUTPUT;
          end else if (timer_tc) begin
            timeout_q <= 1'b1;
            if (tcnt_q != 8'hFF) tcnt_q <= tcnt_q + 8'd1;
            target_q  <= have_target_q ? last_target_q : pitch_q;
            state_q   <= OUTPUT;
          end
        end
        OUTPUT: begin
          if (target_ready_in) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign pitch_ready_out   = (state_q == IDLE);
  assign search_start_out  = (state_q == ISSUE);
  assign target_valid_out  = (state_q == OUTPUT);
  assign search_val_out    = pitch_q;
  assign target_out        = target_q;
  assign timeout_out       = timeout_q;
  assign timeout_count_out = tcnt_q;

endmodule

// File: tb/tb_search_requester.sv
// Directed plus randomized transactions checked against a transaction-level model.
module tb_search_requester;

  localparam int W  = 12;
  localparam int HY = 4;
  localparam int TO = 64;

  logic          clk_in = 1'b0;
  logic          rst_n_in;
  logic          pitch_valid_in;
  logic [W-1:0]  pitch_in;
  logic          pitch_ready_out;
  logic          search_start_out;
  logic [W-1:0]  search_val_out;
  logic [W-1:0]  closest_value_in;
  logic          closest_found_in;
  logic          target_valid_out;
  logic          target_ready_in;
  logic [W-1:0]  target_out;
  logic          timeout_out;
  logic [7:0]    timeout_count_out;

  always #5 clk_in = ~clk_in;

  search_requester #(
    .WIDTH(W),
    .HYST(HY),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_in           (clk_in),
    .rst_n_in         (rst_n_in),
    .pitch_valid_in   (pitch_valid_in),
    .pitch_in         (pitch_in),
    .pitch_ready_out  (pitch_ready_out),
    .search_start_out (search_start_out),
    .search_val_out   (search_val_out),
    .closest_value_in (closest_value_in),
    .closest_found_in (closest_found_in),
    .target_valid_out (target_valid_out),
    .target_ready_in  (target_ready_in),
    .target_out       (target_out),
    .timeout_out      (timeout_out),
    .timeout_count_out(timeout_count_out)
  );

  int checks   = 0;
  int failures = 0;

  // Transaction-level reference state
  bit          m_have;
  logic [W-1:0] m_lp;
  logic [W-1:0] m_lt;
  int          m_tc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_have = 1'b0;
    m_lp   = '0;
    m_lt   = '0;
    m_tc   = 0;
  endtask

  // One full request: dly = WAIT cycle at which found rises (>= TO means never),
  // stale = found already high from ISSUE with a bogus value, hold = cycles of
  // target_ready low in OUTPUT. Entered and left on a negedge.
  task automatic run_txn(input logic [W-1:0] p, input int dly, input bit stale,
                         input int hold, input logic [W-1:0] ans_in);
    logic [W-1:0] ans, exp_t, d;
    bit           search, resp, exp_to, held_ok;
    int           exp_lat, lat;

    ans     = (ans_in != '0) ? ans_in : W'($urandom_range(1, 4095));
    d       = (p >= m_lp) ? (p - m_lp) : (m_lp - p);
    search  = (p != '0) && !(m_have && (d <= HY));
    resp    = search && (dly < TO);
    exp_to  = search && !resp;
    if (p == '0)      exp_t = '0;
    else if (!search) exp_t = m_lt;
    else if (resp)    exp_t = ans;
    else              exp_t = m_have ? m_lt : p;
    exp_lat = !search ? 1 : (resp ? 3 + dly : 2 + TO);

    chk("ready_idle", pitch_ready_out, 1);
    pitch_valid_in = 1'b1;
    pitch_in       = p;
    @(negedge clk_in);
    lat            = 1;
    pitch_valid_in = 1'b0;
    pitch_in       = W'($urandom);
    chk("ready_low", pitch_ready_out, 0);
    chk("start_pulse", search_start_out, search);
    if (search) begin
      chk("search_val", search_val_out, p);
      if (stale) begin
        closest_found_in = 1'b1;
        closest_value_in = 12'd999;
      end
    end

    held_ok = 1'b1;
    while (!target_valid_out && lat < TO + 8) begin
      if (search && lat >= 2) begin
        if (stale && (lat - 2 == dly - 3)) closest_found_in = 1'b0;
        if (resp && (lat - 2 == dly)) begin
          closest_found_in = 1'b1;
          closest_value_in = ans;
        end
      end
      @(negedge clk_in);
      lat++;
      if (!target_valid_out)
        held_ok &= (search_val_out == p) && !search_start_out && !pitch_ready_out;
    end
    if (search) chk("val_held_wait", held_ok, 1);
    chk("latency", lat, exp_lat);
    chk("target", target_out, exp_t);
    chk("timeout_pulse", timeout_out, exp_to);

    if (p == '0) m_have = 1'b0;
    if (resp) begin
      m_have = 1'b1;
      m_lp   = p;
      m_lt   = ans;
    end
    if (exp_to && m_tc < 255) m_tc++;
    chk("timeout_count", timeout_count_out, m_tc);

    closest_found_in = 1'b0;
    held_ok = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk_in);
      held_ok &= target_valid_out && (target_out == exp_t) && !pitch_ready_out && !timeout_out;
    end
    if (hold > 0) chk("target_stable", held_ok, 1);
    target_ready_in = 1'b1;
    @(negedge clk_in);
    target_ready_in = 1'b0;
    chk("back_idle", pitch_ready_out, 1);
    chk("valid_drop", target_valid_out, 0);
  endtask

  initial begin
    logic [W-1:0] p;
    int           r, t, dly;

    rst_n_in         = 1'b0;
    pitch_valid_in   = 1'b0;
    pitch_in         = '0;
    closest_value_in = '0;
    closest_found_in = 1'b0;
    target_ready_in  = 1'b0;
    model_reset();
    repeat (3) @(negedge clk_in);
    chk("rst_ready", pitch_ready_out, 1);
    chk("rst_start", search_start_out, 0);
    chk("rst_sval", search_val_out, 0);
    chk("rst_valid", target_valid_out, 0);
    chk("rst_target", target_out, 0);
    chk("rst_timeout", timeout_out, 0);
    chk("rst_tcount", timeout_count_out, 0);
    rst_n_in = 1'b1;
    @(negedge clk_in);

    // Basic search, hysteresis reuse, hysteresis boundary
    run_txn(12'd440, 40, 1'b0, 0, 12'd466);
    run_txn(12'd443, 40, 1'b0, 0, 12'd0);
    run_txn(12'd445, 10, 1'b0, 0, 12'd0);
    // Unvoiced clears have_target, so a nearby pitch searches again
    run_txn(12'd0, 5, 1'b0, 0, 12'd0);
    run_txn(12'd443, 7, 1'b0, 1, 12'd0);
    // Timeout without a previous target, then with one
    run_txn(12'd0, 5, 1'b0, 0, 12'd0);
    run_txn(12'd300, TO, 1'b0, 0, 12'd0);
    run_txn(12'd300, 3, 1'b0, 0, 12'd0);
    run_txn(12'd2000, TO + 5, 1'b0, 0, 12'd0);
    // Edge on the terminal-count cycle wins
    run_txn(12'd3000, TO - 1, 1'b0, 0, 12'd0);
    // Stale found level masked, slow consumer
    run_txn(12'd1500, 20, 1'b1, 5, 12'd523);

    for (int n = 0; n < 25; n++) begin
      r = $urandom_range(0, 9);
      if (r == 0) begin
        p = '0;
      end else if (r <= 5) begin
        t = int'(m_lp) + int'($urandom_range(0, 10)) - 5;
        if (t < 1) t = 1;
        if (t > 4095) t = 4095;
        p = W'(t);
      end else begin
        p = W'($urandom_range(1, 4095));
      end
      dly = $urandom_range(0, TO + 8);
      run_txn(p, dly, (dly >= 3) && ($urandom_range(0, 3) == 0), $urandom_range(0, 3), 12'd0);
    end

    // Reset in the middle of WAIT
    run_txn(12'd0, 5, 1'b0, 0, 12'd0);
    pitch_valid_in = 1'b1;
    pitch_in       = 12'd1000;
    @(negedge clk_in);
    pitch_valid_in = 1'b0;
    repeat (5) @(negedge clk_in);
    rst_n_in = 1'b0;
    #1;
    chk("midrst_ready", pitch_ready_out, 1);
    chk("midrst_start", search_start_out, 0);
    chk("midrst_sval", search_val_out, 0);
    chk("midrst_valid", target_valid_out, 0);
    chk("midrst_tcount", timeout_count_out, 0);
    model_reset();
    @(negedge clk_in);
    rst_n_in = 1'b1;
    @(negedge clk_in);
    run_txn(12'd1000, 10, 1'b0, 0, 12'd0);

    // Saturate the timeout counter
    for (int n = 0; n < 258; n++) run_txn(12'd300, TO, 1'b0, 0, 12'd0);
    chk("tcount_saturated", timeout_count_out, 255);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/search_requester.md
# search_requester

Initiator side of the semitone-search handshake. Accepts a stream of detected pitch values, drives one start/value request per new pitch into the `searcher` block, waits for its found pulse, and delivers the snapped target with a valid/ready handshake to the pitch-shift stage. It suppresses redundant searches with a hysteresis window and recovers from a non-responding searcher via a timeout.

## Interface

- `WIDTH`, 12, pitch/target value width (unsigned), equal to searcher `WIDTH`
- `HYST`, 4, max |pitch − last searched pitch| that reuses the last target without a search
- `TIMEOUT_CYCLES`, 256, WAIT cycles before abandoning a search (≥ 2·BRAM_SIZE+8)
- `clk_in`  in  1  system clock
- `rst_n_in`  in  1  asynchronous, active-low reset
- `pitch_valid_in`  in  1  detected pitch available
- `pitch_in`  in  WIDTH  detected pitch; 0 = unvoiced
- `pitch_ready_out`  out  1  high only in IDLE
- `search_start_out`  out  1  one-cycle pulse to searcher `start_search`
- `search_val_out`  out  WIDTH  to searcher `search_val`; held stable from ISSUE through WAIT
- `closest_value_in`  in  WIDTH  from searcher `closest_value`
- `closest_found_in`  in  1  from searcher `closest_value_found` (level, ≥1 cycle)
- `target_valid_out`  out  1  target available
- `target_ready_in`  in  1  consumer accepts target
- `target_out`  out  WIDTH  snapped target
- `timeout_out`  out  1  one-cycle pulse when a search times out
- `timeout_count_out`  out  8  saturating count of timeouts since reset

## Operation

- States: IDLE, ISSUE, WAIT, OUTPUT. All outputs driven from registers or state decode only.
- Reset (async): state IDLE, all outputs 0 except `pitch_ready_out` = 1, `have_target` = 0, `last_pitch` = 0, `last_target` = 0, timer 0, `found_d` = 0.
- IDLE: accept on `pitch_valid_in` (ready high). Latch `pitch_q`.
  - `pitch_in` = 0 → `target_q` = 0, clear `have_target`, → OUTPUT (no search).
  - `have_target` and |pitch_in − last_pitch| ≤ HYST → `target_q` = `last_target`, → OUTPUT (no search).
  - else → ISSUE.
- |a − b|: unsigned, computed as (a ≥ b) ? a − b : b − a, WIDTH bits, no overflow.
- ISSUE: `search_start_out` = 1, `search_val_out` = `pitch_q`; → WAIT, timer cleared.
- WAIT: `found_d` registers `closest_found_in` every cycle. Rising edge (found & !found_d) → `target_q` = `closest_value_in`, `last_pitch` = `pitch_q`, `last_target` = `closest_value_in`, set `have_target`, → OUTPUT. A level left high from a prior search is ignored: `found_d` is forced to 1 in ISSUE.
- Timeout: timer reaches TIMEOUT_CYCLES−1 with no edge → `timeout_out` pulse, `timeout_count_out` += 1 saturating at 255, `target_q` = `have_target` ? `last_target` : `pitch_q`, → OUTPUT. `have_target` and `last_*` are unchanged.
- OUTPUT: `target_valid_out` = 1, `target_out` = `target_q` stable until `target_ready_in`. On handshake → IDLE.
- Edge and timeout on the same cycle: the edge wins and there is no timeout pulse.

## Timing

- Bypass path: accept at cycle 0 → `target_valid_out` at cycle 1.
- Search path: accept at 0, `search_start_out` high at cycle 1 only, WAIT from cycle 2; found edge sampled at cycle k → `target_valid_out` at k+1.
- Throughput: one pitch per transaction; `pitch_ready_out` is low from the accept cycle+1 until return to IDLE.
- `target_ready_in` held high → OUTPUT lasts exactly 1 cycle.
- Reset mid-WAIT: the searcher may still be running. The next ISSUE restarts it, because its start has priority, and the stale found is masked by the `found_d` preset.

## Structure

- Package `autotune_pkg`: `req_state_t` enum (IDLE, ISSUE, WAIT, OUTPUT), default `WIDTH` = 12, `TIMEOUT_CYCLES` default.
- One natural sub-module: `search_timer` (clearable counter with terminal-count flag, parameter `TIMEOUT_CYCLES`).

## Test plan

- Pitch 440, searcher model answers 466 after 40 cycles → one `search_start_out` pulse, `search_val_out` = 440 held, `target_out` = 466 valid one cycle after the found edge.
- After the previous test, pitch 443 (within HYST = 4) → no start pulse, `target_out` = 466 at cycle 1; pitch 445 → new search issued.
- Pitch 0 → `target_out` = 0 at cycle 1, no search; next pitch 443 → search issued because `have_target` was cleared.
- Searcher never asserts found: 300 → `timeout_out` pulse at WAIT cycle 255, `target_out` = 300, `timeout_count_out` = 1; repeat 300 times → saturates at 255.
- Found held high on entry to WAIT, edge 20 cycles later with 523 → captures 523, not the stale value; `target_ready_in` low for 5 cycles → `target_out` stable, `pitch_ready_out` low throughout.
- `rst_n_in` asserted mid-WAIT → outputs cleared immediately, `pitch_ready_out` = 1; next request completes normally.
